clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Programmable, glitch-free clock-divider controller for the clock-generation area. It produces a divided clock clk_out from clk_in with a runtime-selectable ratio N. Ratio changes arrive over a valid/ready config port and are applied only at period boundaries. Start and stop, gated by enable, always complete whole periods, so clk_out never shows a runt pulse. It is the sequencing and configuration front end for the fixed divide-by-2/4 toggle dividers.

Parameters:
DIV_W, 8, width of the divide-ratio field; legal N range is 2 .. 2^DIV_W-1
DEFAULT_DIV, 4, ratio loaded into cur_div at reset; must be >= 2

Ports:
clk_in  input  1  source clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  run request; level-sensitive
cfg_valid  input  1  new ratio offered
cfg_div  input  DIV_W  requested ratio N
cfg_ready  output  1  config port can accept
cfg_err  output  1  1-cycle pulse: offered ratio rejected (N<2)
clk_out  output  1  divided clock, registered
tick  output  1  1-cycle pulse on the clk_in cycle in which clk_out first goes high each period
busy  output  1  state != IDLE
cur_div  output  DIV_W  ratio currently in effect

Behaviour:
- Reset is asynchronous, active-high; clock is clk_in. Reset values:
  - state=IDLE, clk_out=0, tick=0, cfg_err=0, busy=0, cfg_ready=1
  - cur_div=DEFAULT_DIV, cnt=0, pend_valid=0
- All outputs are registered; no combinational path from input to output except cfg_ready, which is decoded from registered state only.
- Waveform for ratio N:
  - Each period lasts N clk_in cycles.
  - clk_out is high for floor(N/2) cycles, then low for ceil(N/2) cycles.
  - Internal cnt runs 0..N-1, with clk_out = (cnt < N/2).
- States:
  - IDLE: clk_out=0, cnt=0. An edge sampling enable=1 moves to RUN. At that edge cnt<=0, clk_out<=1, tick<=1. Latency from enable sampled to clk_out high is 1 edge.
  - RUN: cnt increments each edge. At an edge where cnt==N-1 (period end):
    - if enable=1, start a new period: cnt<=0, clk_out<=1, tick<=1.
    - if enable=0, go to IDLE with clk_out held 0.
    - Deasserting enable mid-period never truncates the period.
  - PEND: same waveform as RUN, with a ratio change waiting. At period end, cur_div<=pend_div and pend_valid<=0. The next period, or the IDLE state, uses the new N. State then returns to RUN or IDLE per enable.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready. cfg_ready = !pend_valid.
  - cfg_div < 2 is accepted but discarded: cfg_err pulses high on the next cycle and cur_div is unchanged.
  - Legal N in IDLE: cur_div updates at the accepting edge, with no pending stage.
  - Legal N in RUN: latched into pend_div and state goes to PEND. cfg_ready stays low until the boundary applies it.
- Simultaneous events:
  - A transfer on the same edge as a period end is not applied at that boundary; it applies at the following boundary.
  - A transfer on the same edge as IDLE->RUN start applies at the first period end.
  - An enable drop and a pending change at the same boundary: the change is applied and the block enters IDLE with the new cur_div.
- Reset mid-operation: clk_out drops to 0 immediately (async). Any pending ratio is discarded and cur_div returns to DEFAULT_DIV.
- Ratio 2^DIV_W-1 is the maximum. cnt is DIV_W bits wide and never wraps past N-1.

Test Plan:
- Default run: release reset, enable=1 held. clk_out repeats 1,1,0,0 (period 4) starting 1 edge after enable; tick every 4th cycle; cur_div=4.
- Odd ratio: in IDLE, write cfg_div=5, then enable. clk_out pattern is 2 high, 3 low; tick period 5; cur_div=5 the cycle after the transfer.
- Mid-run change: running N=4, write cfg_div=6 at cnt=1. cfg_ready falls and the current period finishes as 4 cycles. The next periods are 3 high, 3 low; cfg_ready rises at that boundary.
- Illegal ratio: write cfg_div=1 (also 0). cfg_err is a single-cycle pulse, cur_div is unchanged, and the waveform is undisturbed.
- Glitch-free stop: N=6, drop enable at cnt=1. clk_out completes 3 high, 3 low, then stays 0; busy falls at the boundary; no tick afterwards.
- Reset mid-run: N=6 pending, N=8 running, assert reset at cnt=2. clk_out=0 immediately; after release cur_div=4 and the pending 6 is lost.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable glitch-free clock divider controller: whole-period start/stop and
// ratio changes applied only at period boundaries through a valid/ready port.
module clk_div_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    state_t           state_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] pend_div_r;
    logic             pend_valid_r;

    logic [DIV_W-1:0] half_s;
    logic [DIV_W-1:0] cnt_next_s;
    logic             xfer_s;
    logic             legal_xfer_s;
    logic             period_end_s;

    // Handshake and period decode from registered state and the offered ratio
    always_comb begin
        half_s       = cur_div >> 1;
        cnt_next_s   = cnt_r + ONE;
        xfer_s       = cfg_valid && !pend_valid_r;
        legal_xfer_s = xfer_s && (cfg_div >= MIN_DIV);
        period_end_s = (cnt_r == (cur_div - ONE));
    end

    assign cfg_ready = !pend_valid_r;

    // Sequencer: waveform generation, start/stop at boundaries, ratio staging
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            pend_div_r   <= '0;
            pend_valid_r <= 1'b0;
            cur_div      <= DEF_DIV;
            clk_out      <= 1'b0;
            tick         <= 1'b0;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            tick    <= 1'b0;
            cfg_err <= xfer_s && !legal_xfer_s;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (enable) begin
                        clk_out <= 1'b1;
                        tick    <= 1'b1;
                        busy    <= 1'b1;
                        if (legal_xfer_s) begin
                            pend_div_r   <= cfg_div;
                            pend_valid_r <= 1'b1;
                            state_r      <= PEND;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        clk_out <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                        if (legal_xfer_s) begin
                            cur_div <= cfg_div;
                        end
                    end
                end
                RUN, PEND: begin
                    if (period_end_s) begin
                        cnt_r        <= '0;
                        pend_valid_r <= enable && legal_xfer_s;
                        if (legal_xfer_s) begin
                            pend_div_r <= cfg_div;
                        end
                        // A staged ratio always wins; a fresh offer while stopping goes straight in
                        if (pend_valid_r) begin
                            cur_div <= pend_div_r;
                        end else if (!enable && legal_xfer_s) begin
                            cur_div <= cfg_div;
                        end
                        if (enable) begin
                            clk_out <= 1'b1;
                            tick    <= 1'b1;
                            busy    <= 1'b1;
                            state_r <= legal_xfer_s ? PEND : RUN;
                        end else begin
                            clk_out <= 1'b0;
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r   <= cnt_next_s;
                        clk_out <= (cnt_next_s < half_s);
                        if (legal_xfer_s) begin
                            pend_div_r   <= cfg_div;
                            pend_valid_r <= 1'b1;
                            state_r      <= PEND;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= '0;
                    pend_valid_r <= 1'b0;
                    clk_out      <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period-position model queues expected
// outputs per driven edge; they are popped and compared after the edge.
module tb_clk_div_ctrl;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       enable;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic [7:0] cur_div;

    clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(4)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .cur_div   (cur_div)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic       clk_out;
        logic       tick;
        logic       busy;
        logic       cfg_ready;
        logic       cfg_err;
        logic [7:0] cur_div;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    bit   m_run;
    int   m_pos;
    int   m_n;
    bit   m_pend;
    int   m_pend_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_pos = 0; m_n = 4; m_pend = 1'b0; m_pend_n = 0;
    endtask

    // Advance the reference model by one clk_in edge using the driven inputs
    task automatic model_edge();
        exp_t e;
        bit xf, lg;
        xf = cfg_valid && !m_pend;
        lg = (cfg_div >= 8'd2);
        e.cfg_err = xf && !lg;
        if (!m_run) begin
            if (enable) begin
                m_run = 1'b1; m_pos = 0;
                if (xf && lg) begin m_pend = 1'b1; m_pend_n = cfg_div; end
            end else if (xf && lg) begin
                m_n = cfg_div;
            end
        end else if (m_pos == m_n - 1) begin
            if (m_pend) begin m_n = m_pend_n; m_pend = 1'b0; end
            m_pos = 0;
            if (enable) begin
                if (xf && lg) begin m_pend = 1'b1; m_pend_n = cfg_div; end
            end else begin
                m_run = 1'b0;
                if (xf && lg) m_n = cfg_div;
            end
        end else begin
            m_pos++;
            if (xf && lg) begin m_pend = 1'b1; m_pend_n = cfg_div; end
        end
        e.clk_out   = m_run && (m_pos < m_n / 2);
        e.tick      = m_run && (m_pos == 0);
        e.busy      = m_run;
        e.cfg_ready = !m_pend;
        e.cur_div   = 8'(m_n);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic en, input logic cv, input logic [7:0] cd);
        exp_t e;
        enable = en; cfg_valid = cv; cfg_div = cd;
        model_edge();
        @(posedge clk_in);
        #1;
        e = exp_q.pop_front();
        chk("clk_out",   {31'd0, clk_out},   {31'd0, e.clk_out});
        chk("tick",      {31'd0, tick},      {31'd0, e.tick});
        chk("busy",      {31'd0, busy},      {31'd0, e.busy});
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, e.cfg_ready});
        chk("cfg_err",   {31'd0, cfg_err},   {31'd0, e.cfg_err});
        chk("cur_div",   {24'd0, cur_div},   {24'd0, e.cur_div});
        cfg_valid = 1'b0;
    endtask

    task automatic run_n(input logic en, input int n);
        for (int i = 0; i < n; i++) step(en, 1'b0, 8'd0);
    endtask

    // Run enabled until the next edge will sample the given period position
    task automatic run_to_pos(input int pos);
        bit hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            if (m_run && m_pos == pos) hit = 1'b1;
            else step(1'b1, 1'b0, 8'd0);
        end
        chk("run_to_pos_timeout", {31'd0, hit}, 32'd1);
    endtask

    task automatic go_idle();
        bit hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            if (!m_run) hit = 1'b1;
            else step(1'b0, 1'b0, 8'd0);
        end
        chk("go_idle_timeout", {31'd0, hit}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_clk_out",   {31'd0, clk_out},   32'd0);
        chk("rst_tick",      {31'd0, tick},      32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_cfg_err",   {31'd0, cfg_err},   32'd0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_cur_div",   {24'd0, cur_div},   32'd4);
        reset = 1'b0;

        // Default ratio 4, enable held
        run_n(1'b1, 13);
        go_idle();

        // Odd ratio 5 written in IDLE, then run
        step(1'b0, 1'b1, 8'd5);
        run_n(1'b1, 16);
        go_idle();

        // Mid-run change 4 -> 6 offered at cnt=1
        step(1'b0, 1'b1, 8'd4);
        run_n(1'b1, 2);
        run_to_pos(1);
        step(1'b1, 1'b1, 8'd6);
        run_n(1'b1, 20);

        // Illegal ratios leave the waveform and ratio untouched
        step(1'b1, 1'b1, 8'd1);
        run_n(1'b1, 3);
        step(1'b1, 1'b1, 8'd0);
        run_n(1'b1, 4);

        // Glitch-free stop at cnt=1 with N=6
        run_to_pos(1);
        run_n(1'b0, 10);

        // Transfer on the same edge as a period end, and as the IDLE->RUN start
        run_n(1'b1, 1);
        run_to_pos(5);
        step(1'b1, 1'b1, 8'd3);
        run_n(1'b1, 14);
        go_idle();
        step(1'b1, 1'b1, 8'd7);
        run_n(1'b1, 12);

        // Enable drop coinciding with a pending change at the boundary
        run_to_pos(2);
        step(1'b1, 1'b1, 8'd2);
        run_n(1'b0, 10);
        chk("idle_new_div", {24'd0, cur_div}, 32'd2);

        // Maximum ratio: one full period plus the next start
        step(1'b0, 1'b1, 8'd255);
        run_n(1'b1, 257);
        go_idle();

        // Reset mid-run: N=8 running, 6 pending, reset at cnt=2
        step(1'b0, 1'b1, 8'd8);
        run_n(1'b1, 1);
        step(1'b1, 1'b1, 8'd6);
        run_to_pos(2);
        #1;
        reset = 1'b1;
        #1;
        chk("async_clk_out",   {31'd0, clk_out},   32'd0);
        chk("async_busy",      {31'd0, busy},      32'd0);
        chk("async_cur_div",   {24'd0, cur_div},   32'd4);
        chk("async_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        #1;
        reset = 1'b0;
        model_reset();
        run_n(1'b0, 2);
        run_n(1'b1, 9);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
